adder_gather: RTL and testbench

//   Serial-to-parallel front end for the adder tree. Takes one BITS-wide sample per

---
 rtl/adder_pkg.sv | 20 ++
 rtl/adder_gather_if.sv | 25 ++
 rtl/adder_gather.sv | 76 +++++++
 tb/tb_adder_gather.sv | 133 +++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared helpers for the adder tree and its front ends: lane counter width
// and the parameter legality checks used at elaboration.
package adder_pkg;

   // Width of a counter that indexes num lanes (0..num-1).
   function automatic int lane_cnt_w(input int num);
      return $clog2(num);
   endfunction

   // Lane count must be a power of two and at least two.
   function automatic bit num_ok(input int num);
      return (num >= 2) && ((num & (num - 1)) == 0);
   endfunction

   // Samples must carry at least one bit.
   function automatic bit bits_ok(input int bits);
      return bits >= 1;
   endfunction

endpackage

// File: rtl/adder_gather_if.sv
// Sample-in / group-out bus of the gather stage. The master side produces
// samples and consumes groups; the slave side is the gather block itself.
interface adder_gather_if
   import adder_pkg::*;
#(
   parameter int BITS = 8,
   parameter int NUM  = 4
);
   logic                       in_valid;
   logic [BITS-1:0]            in_data;
   logic                       in_last;
   logic                       valid_out;
   logic [NUM*BITS-1:0]        data_out;
   logic [lane_cnt_w(NUM):0]   lanes_out;

   modport master (
      output in_valid, in_data, in_last,
      input  valid_out, data_out, lanes_out
   );

   modport slave (
      input  in_valid, in_data, in_last,
      output valid_out, data_out, lanes_out
   );
endinterface

// File: rtl/adder_gather.sv
// Serial-to-parallel front end for the adder tree: packs up to NUM samples
// into one flat lane bus, lane 0 oldest, and pulses valid_out one cycle after
// the closing sample. Partial groups (closed by in_last) are zero-padded so
// the downstream sum stays exact.
module adder_gather
   import adder_pkg::*;
#(
   parameter int BITS = 8,
   parameter int NUM  = 4
) (
   input logic           clk,
   input logic           rst_n,
   adder_gather_if.slave bus
);
   localparam int CNT_W = lane_cnt_w(NUM);
   localparam int W     = NUM * BITS;
   localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(NUM - 1);

   // Reject illegal configurations at elaboration time.
   if (!num_ok(NUM)) begin : g_bad_num
      $error("adder_gather: NUM must be a power of two >= 2");
   end
   if (!bits_ok(BITS)) begin : g_bad_bits
      $error("adder_gather: BITS must be >= 1");
   end

   logic [CNT_W-1:0] cnt;
   logic [W-1:0]     shadow;
   logic [W-1:0]     merged;
   logic             closing;
   logic             valid_q;
   logic [W-1:0]     data_q;
   logic [CNT_W:0]   lanes_q;

   // Shadow lanes with the current sample dropped into lane cnt.
   always_comb begin
      // NOTE: every always_comb output gets a full default first so no path can infer a latch.
      merged = shadow;
      merged[cnt*BITS +: BITS] = bus.in_data;
   end

   // A group closes on an accepted sample in the last lane or flagged last.
   assign closing = bus.in_valid && (bus.in_last || (cnt == LAST_LANE));

   // Lane counter, shadow lanes and registered group outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the shadow lanes are reset, not just the counter: padding relies on unused lanes being zero.
         cnt     <= '0;
         shadow  <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
         lanes_q <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         valid_q <= 1'b0;
         if (bus.in_valid) begin
            if (closing) begin
               valid_q <= 1'b1;
               data_q  <= merged;
               lanes_q <= {1'b0, cnt} + (CNT_W+1)'(1);
               cnt     <= '0;
               shadow  <= '0;
            end else begin
               shadow  <= merged;
               cnt     <= cnt + CNT_W'(1);
            end
         end
      end
   end

   assign bus.valid_out = valid_q;
   assign bus.data_out  = data_q;
   assign bus.lanes_out = lanes_q;

endmodule

// File: tb/tb_adder_gather.sv
// Directed bench for adder_gather (BITS=8, NUM=4). Inputs change on the
// falling edge; outputs are checked on the following falling edge, i.e. half
// a cycle after the rising edge that captured the inputs.
module tb_adder_gather;
   localparam int BITS = 8;
   localparam int NUM  = 4;

   logic clk;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   adder_gather_if #(.BITS(BITS), .NUM(NUM)) bus ();

   adder_gather #(.BITS(BITS), .NUM(NUM)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its expected value.
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present one input set for a full clock; return on the next falling edge.
   task automatic cycle(input logic v, input logic [7:0] d, input logic l);
      bus.in_valid = v;
      bus.in_data  = d;
      bus.in_last  = l;
      @(negedge clk);
   endtask

   // Check the complete output triple.
   task automatic check_group(input string tag, input logic v, input logic [31:0] d,
                              input logic [2:0] n);
      check({tag, ".valid"}, 64'(bus.valid_out), 64'(v));
      check({tag, ".data"},  64'(bus.data_out),  64'(d));
      check({tag, ".lanes"}, 64'(bus.lanes_out), 64'(n));
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.in_last  = 1'b0;
      rst_n        = 1'b0;

      // Reset held for three cycles.
      repeat (3) @(negedge clk);
      check_group("reset", 1'b0, 32'h0, 3'd0);
      rst_n = 1'b1;

      // Full group.
      cycle(1'b1, 8'h01, 1'b0);
      cycle(1'b1, 8'h02, 1'b0);
      cycle(1'b1, 8'h03, 1'b0);
      check("full.no_early_pulse", 64'(bus.valid_out), 64'(0));
      cycle(1'b1, 8'h04, 1'b0);
      check_group("full", 1'b1, 32'h04030201, 3'd4);
      cycle(1'b0, 8'h00, 1'b0);
      check_group("full.hold", 1'b0, 32'h04030201, 3'd4);

      // Partial group closed by in_last.
      cycle(1'b1, 8'h10, 1'b0);
      check("partial.no_early_pulse", 64'(bus.valid_out), 64'(0));
      cycle(1'b1, 8'h20, 1'b1);
      check_group("partial", 1'b1, 32'h00002010, 3'd2);
      cycle(1'b0, 8'h00, 1'b0);
      check("partial.single_pulse", 64'(bus.valid_out), 64'(0));

      // Back-to-back groups, no bubble between them.
      for (int i = 1; i <= 8; i++) begin
         cycle(1'b1, 8'(i), 1'b0);
         check($sformatf("b2b.valid%0d", i), 64'(bus.valid_out), 64'((i % 4) == 0));
         if (i == 4) check_group("b2b.first", 1'b1, 32'h04030201, 3'd4);
      end
      check_group("b2b.second", 1'b1, 32'h08070605, 3'd4);
      cycle(1'b0, 8'h00, 1'b0);
      check("b2b.end", 64'(bus.valid_out), 64'(0));

      // Idle gaps and an unqualified in_last inside a group.
      cycle(1'b1, 8'hAA, 1'b0);
      cycle(1'b0, 8'h00, 1'b0);
      cycle(1'b0, 8'h00, 1'b0);
      cycle(1'b0, 8'hEE, 1'b1);
      check("gap.spurious_last", 64'(bus.valid_out), 64'(0));
      cycle(1'b1, 8'hBB, 1'b0);
      cycle(1'b1, 8'hCC, 1'b0);
      check("gap.no_early_pulse", 64'(bus.valid_out), 64'(0));
      cycle(1'b1, 8'hDD, 1'b0);
      check_group("gap", 1'b1, 32'hDDCCBBAA, 3'd4);

      // One-lane group: in_last on the first sample.
      cycle(1'b1, 8'h5A, 1'b1);
      check_group("one_lane", 1'b1, 32'h0000005A, 3'd1);

      // in_last on the fourth sample: ordinary full group, one pulse.
      cycle(1'b1, 8'h91, 1'b0);
      cycle(1'b1, 8'h92, 1'b0);
      cycle(1'b1, 8'h93, 1'b0);
      cycle(1'b1, 8'h94, 1'b1);
      check_group("last_full", 1'b1, 32'h94939291, 3'd4);
      cycle(1'b0, 8'h00, 1'b0);
      check("last_full.single_pulse", 64'(bus.valid_out), 64'(0));

      // Reset in the middle of a group discards it.
      cycle(1'b1, 8'h11, 1'b0);
      cycle(1'b1, 8'h22, 1'b0);
      rst_n = 1'b0;
      cycle(1'b0, 8'h00, 1'b0);
      check_group("midreset", 1'b0, 32'h0, 3'd0);
      rst_n = 1'b1;
      cycle(1'b1, 8'h33, 1'b0);
      cycle(1'b1, 8'h44, 1'b0);
      cycle(1'b1, 8'h55, 1'b0);
      check("midreset.no_stale_pulse", 64'(bus.valid_out), 64'(0));
      cycle(1'b1, 8'h66, 1'b0);
      check_group("midreset.after", 1'b1, 32'h66554433, 3'd4);
      cycle(1'b0, 8'h00, 1'b0);
      check("midreset.single_pulse", 64'(bus.valid_out), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
